serial_frame_tx: RTL
====================

# serial_frame_tx

Serial frame transmitter: accepts a parallel word over a valid/ready handshake and drives it onto a single-bit line as a framed bit stream. The frame is a start bit, data MSB-first, then a stop bit. Each bit is held for a programmable number of clocks. The block is the driving end of the single-bit `in` line consumed by the team's Moore sequence-detector FSMs. It sits between a word-producing source and that detector, and its `out` connects directly to the detector's `in`.

## Interface
Parameters:
- `WIDTH`, 8, data bits per frame (>= 1)
- `BIT_CYCLES`, 1, clocks each bit is held on `out` (>= 1)

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `data_in`  in  WIDTH  word to transmit
- `data_valid`  in  1  source has a word
- `data_ready`  out  1  block accepts `data_in` this cycle
- `out`  out  1  serial line, idle level 0
- `busy`  out  1  frame in progress
- `done`  out  1  one-cycle pulse after a frame's stop bit completes

## Operation
- Moore FSM with four states:
  - IDLE: `out`=0.
  - START: `out`=1.
  - DATA: `out`=shift_reg MSB.
  - STOP: `out`=0.
- `out` and `busy` are decoded from registered state only, never from inputs.
- Accept when `data_valid && data_ready`. On accept, `data_in` is captured into `shift_reg` and the next state is START. Later changes to `data_in` have no effect on the frame.
- `data_ready` = (state==IDLE) || (state==STOP && bit_timer at last cycle).
- Bit timer counts 0..BIT_CYCLES-1 and reloads to 0 on every state change and every data-bit advance.
- Transitions:
  - IDLE→START on accept.
  - START→DATA at timer end.
  - In DATA: at timer end, shift left 1. After WIDTH bits, go to STOP.
  - STOP→START at timer end if accepting (back-to-back, no idle gap). Otherwise STOP→IDLE.
- Data bit counter counts 0..WIDTH-1. Width is clog2(WIDTH), minimum 1. Timer width is clog2(BIT_CYCLES), minimum 1.
- `busy` = state != IDLE.
- `done` is a registered pulse. It is high for exactly one cycle following the last STOP cycle of every frame, including back-to-back frames.
- Reset values: state=IDLE, `out`=0, `busy`=0, `done`=0, `data_ready`=1, shift_reg=0, counters=0.
- Reset mid-frame: the frame is abandoned immediately (asynchronously) with no `done` pulse. The first accept after release starts a clean frame.

## Timing
- Accept at edge k: `out`=1 during the cycles following edges k..k+BIT_CYCLES-1.
- Frame occupies exactly (WIDTH+2)*BIT_CYCLES cycles of `out`.
- Latency from accept edge to start bit on `out`: 0 cycles after the edge (registered).
- `data_ready` is high for exactly one cycle per frame during STOP. A source that holds `data_valid` gets back-to-back frames.
- `data_valid` while `data_ready`=0 is ignored and does not queue.
- `done` from frame N and the start bit of frame N+1 coincide in back-to-back operation.
- BIT_CYCLES=1: every state and bit lasts one cycle, and the timer is always at its last cycle.

## Structure
- Shared package `serial_frame_pkg`:
  - state typedef (IDLE/START/DATA/STOP)
  - constants START_LEVEL=1, STOP_LEVEL=0, IDLE_LEVEL=0
  - the clog2-minimum-1 width function

  The detector side reuses the same package.
- One sub-module `serial_bit_timer`:
  - parameter BIT_CYCLES
  - inputs `clk`, `reset_n`, `restart`
  - output `last`
- FSM, shift register and data bit counter live in `serial_frame_tx`.

## Test plan
- Reset: `reset_n`=0 with random inputs gives `out`=0, `busy`=0, `done`=0, `data_ready`=1. Release with `data_valid`=0 keeps the line at 0 for 10 cycles.
- Single frame, WIDTH=8, BIT_CYCLES=2, `data_in`=0xA5: `out` is 1, then 1,0,1,0,0,1,0,1, then 0, each bit held 2 cycles (20 cycles total). Exactly one `done` pulse follows, then IDLE.
- Back-to-back 0xFF then 0x00 with `data_valid` held high: no idle gap. `data_ready` is high exactly 1 cycle per frame, there are two `done` pulses, and `out` goes 1,1×8,0 then 1,0×8,0.
- Ignored input: `data_valid`=1 with a changing `data_in` mid-frame of 0x3C. Transmitted bits remain 0,0,1,1,1,1,0,0, and no extra frame starts.
- Reset mid-frame: `reset_n` dropped during DATA of 0x3C forces `out`=0 and `busy`=0 without a clock edge, and no `done` is produced. After release, a frame of 0x81 transmits correctly.
- BIT_CYCLES=1, WIDTH=8, `data_in`=0x01: 10-cycle frame 1,0,0,0,0,0,0,0,1,0, with `done` on cycle 11.

Source files
------------

// File: rtl/serial_frame_pkg.sv
// Shared definitions for the serial frame transmitter and the sequence detectors it drives.
package serial_frame_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } frame_state_e;

  localparam logic START_LEVEL = 1'b1;
  localparam logic STOP_LEVEL  = 1'b0;
  localparam logic IDLE_LEVEL  = 1'b0;

  // Counter width for a range of v values, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Per-bit hold timer: counts 0..BIT_CYCLES-1 and flags the final cycle of each bit.
module serial_bit_timer
  import serial_frame_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  output logic last
);

  localparam int unsigned TW = clog2_min1(BIT_CYCLES);

  logic [TW-1:0] cnt_q, cnt_d;

  assign last = (cnt_q == TW'(BIT_CYCLES - 1));

  // Every bit boundary coincides with 'last', so wrapping there doubles as the reload.
  always_comb begin
    cnt_d = cnt_q + TW'(1);
    if (restart || last) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/serial_frame_tx.sv
// Framed serial transmitter: start bit, WIDTH data bits MSB-first, stop bit.
module serial_frame_tx
  import serial_frame_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned BIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             out,
  output logic             busy,
  output logic             done
);

  localparam int unsigned BW = clog2_min1(WIDTH);

  frame_state_e     state_q;
  logic [WIDTH-1:0] shift_q;
  logic [BW-1:0]    bit_cnt_q;
  logic             done_q;
  logic             last;
  logic             accept;

  serial_bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .restart(state_q == IDLE),
    .last   (last)
  );

  assign data_ready = (state_q == IDLE) || ((state_q == STOP) && last);
  assign accept     = data_valid && data_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= (state_q == STOP) && last;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            shift_q <= data_in;
            state_q <= START;
          end
        end
        START: begin
          if (last) begin
            bit_cnt_q <= '0;
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (last) begin
            shift_q <= shift_q << 1;
            if (bit_cnt_q == BW'(WIDTH - 1)) begin
              bit_cnt_q <= '0;
              state_q   <= STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + BW'(1);
            end
          end
        end
        STOP: begin
          if (last) begin
            if (accept) begin
              shift_q <= data_in;
              state_q <= START;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    out = IDLE_LEVEL;
    unique case (state_q)
      IDLE:    out = IDLE_LEVEL;
      START:   out = START_LEVEL;
      DATA:    out = shift_q[WIDTH-1];
      STOP:    out = STOP_LEVEL;
      default: out = IDLE_LEVEL;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule
